// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ADD/SUB/AND/XOR with valid/ready handshake; the carry chain is resolved CHUNK bits per stage.
// Optional condition-code register enabled by defining ALU_PIPE_CC_EN.
module alu_pipe #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);
    localparam int unsigned NSTAGE = WIDTH / CHUNK;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    logic             stall;

    logic             in_v  [NSTAGE];
    op_e              in_op [NSTAGE];
    logic             in_c  [NSTAGE];
    logic [WIDTH-1:0] in_x  [NSTAGE];
    logic [WIDTH-1:0] in_y  [NSTAGE];
    logic [WIDTH-1:0] in_r  [NSTAGE];

    logic [CHUNK:0]   sum   [NSTAGE];
    logic             c_d   [NSTAGE];
    logic [WIDTH-1:0] r_d   [NSTAGE];

    logic             v_q   [NSTAGE];
    op_e              op_q  [NSTAGE];
    logic             c_q   [NSTAGE];
    logic [WIDTH-1:0] x_q   [NSTAGE];
    logic [WIDTH-1:0] y_q   [NSTAGE];
    logic [WIDTH-1:0] r_q   [NSTAGE];

    assign out_valid = v_q[NSTAGE-1];
    assign result    = r_q[NSTAGE-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    // SUB is b - a: b becomes the left operand, a is inverted and carry-in is 1.
    always_comb begin
        in_v[0]  = in_valid;
        in_op[0] = op_e'(op);
        in_x[0]  = (op_e'(op) == OP_SUB) ? b : a;
        in_y[0]  = (op_e'(op) == OP_SUB) ? ~a : b;
        in_c[0]  = (op_e'(op) == OP_SUB);
        in_r[0]  = '0;
        for (int unsigned k = 1; k < NSTAGE; k++) begin
            in_v[k]  = v_q[k-1];
            in_op[k] = op_q[k-1];
            in_x[k]  = x_q[k-1];
            in_y[k]  = y_q[k-1];
            in_c[k]  = c_q[k-1];
            in_r[k]  = r_q[k-1];
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            sum[k] = {1'b0, in_x[k][k*CHUNK +: CHUNK]}
                   + {1'b0, in_y[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, in_c[k]};
            c_d[k] = sum[k][CHUNK];
            r_d[k] = in_r[k];
            case (in_op[k])
                OP_ADD, OP_SUB: r_d[k][k*CHUNK +: CHUNK] = sum[k][CHUNK-1:0];
                OP_AND:         r_d[k][k*CHUNK +: CHUNK] = in_x[k][k*CHUNK +: CHUNK] & in_y[k][k*CHUNK +: CHUNK];
                default:        r_d[k][k*CHUNK +: CHUNK] = in_x[k][k*CHUNK +: CHUNK] ^ in_y[k][k*CHUNK +: CHUNK];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                v_q[k]  <= 1'b0;
                op_q[k] <= OP_ADD;
                c_q[k]  <= 1'b0;
                x_q[k]  <= '0;
                y_q[k]  <= '0;
                r_q[k]  <= '0;
            end
        end else if (!stall) begin
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                v_q[k]  <= in_v[k];
                op_q[k] <= in_op[k];
                c_q[k]  <= c_d[k];
                x_q[k]  <= in_x[k];
                y_q[k]  <= in_y[k];
                r_q[k]  <= r_d[k];
            end
        end
    end

    // Operands were swapped/inverted at entry, so ADD and SUB share one sign test.
    assign overflow = !op_q[NSTAGE-1][1]
                   && (x_q[NSTAGE-1][WIDTH-1] == y_q[NSTAGE-1][WIDTH-1])
                   && (result[WIDTH-1] != x_q[NSTAGE-1][WIDTH-1]);

    logic unused_tail;
    assign unused_tail = ^{c_q[NSTAGE-1], op_q[NSTAGE-1][0], x_q[NSTAGE-1], y_q[NSTAGE-1]};

`ifdef ALU_PIPE_CC_EN
    logic cc_q [NSTAGE];
    logic zf_q, sf_q, of_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                cc_q[k] <= 1'b0;
            end
        end else if (!stall) begin
            cc_q[0] <= set_cc;
            for (int unsigned k = 1; k < NSTAGE; k++) begin
                cc_q[k] <= cc_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (out_valid && out_ready && cc_q[NSTAGE-1]) begin
            zf_q <= (result == '0);
            sf_q <= result[WIDTH-1];
            of_q <= overflow;
        end
    end

    assign cc_zf = zf_q;
    assign cc_sf = sf_q;
    assign cc_of = of_q;
`else
    logic unused_set_cc;
    assign unused_set_cc = set_cc;
    assign cc_zf = 1'b1;
    assign cc_sf = 1'b0;
    assign cc_of = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=64, CHUNK=16): directed steps plus a scoreboard queue of expected results.
module tb_alu_pipe;
    localparam int W   = 64;
    localparam int NST = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         set_cc = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         overflow;
    logic         cc_zf, cc_sf, cc_of;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(64), .CHUNK(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .set_cc(set_cc), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .overflow(overflow),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         ov;
        logic         scc;
        int           acc;
        int           lat;
    } exp_t;

    exp_t         sbq[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    int           stall_lo = -1;
    int           stall_hi = -1;
    bit           rnd_ordy = 1'b0;
    logic         m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_res = '0;
    logic         prev_ov = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s);
        exp_t e;
        e.scc = s;
        e.acc = 0;
        e.lat = 0;
        case (o)
            2'b00:   e.res = x + y;
            2'b01:   e.res = y - x;
            2'b10:   e.res = x & y;
            default: e.res = x ^ y;
        endcase
        if (o == 2'b00)      e.ov = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
        else if (o == 2'b01) e.ov = (x[W-1] != y[W-1]) && (e.res[W-1] != y[W-1]);
        else                 e.ov = 1'b0;
        return e;
    endfunction

    function automatic logic ordy_now();
        if (rnd_ordy) return 1'($urandom_range(0, 1));
        return !(cyc >= stall_lo && cyc <= stall_hi);
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called at a falling edge; holds the op until accepted, then returns at the next falling edge.
    task automatic send(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input int lat);
        exp_t e;
        int   guard;
        e = model(o, x, y, s);
        guard = 0;
        in_valid = 1'b1; op = o; a = x; b = y; set_cc = s;
        forever begin
            out_ready = ordy_now();
            #1;
            if (in_ready) begin
                e.acc = cyc;
                e.lat = lat;
                sbq.push_back(e);
                @(negedge clk);
                break;
            end
            guard++;
            if (guard > 50) begin
                chk("in_ready_timeout", in_ready, 1);
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            out_ready = ordy_now();
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            chk("cc_zf", cc_zf, m_zf);
            chk("cc_sf", cc_sf, m_sf);
            chk("cc_of", cc_of, m_of);
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_result", result, prev_res);
                chk("hold_overflow", overflow, prev_ov);
            end
            prev_hold = out_valid && !out_ready;
            prev_res  = result;
            prev_ov   = overflow;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("result", result, e.res);
                    chk("overflow", overflow, e.ov);
                    if (e.lat > 0) chk("latency", cyc - e.acc, e.lat);
`ifdef ALU_PIPE_CC_EN
                    if (e.scc) begin
                        m_zf = (e.res == '0);
                        m_sf = e.res[W-1];
                        m_of = e.ov;
                    end
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int t0;
        int guard;

        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_cc_zf", cc_zf, 1);
        chk("rst_cc_sf", cc_sf, 0);
        chk("rst_cc_of", cc_of, 0);
        @(negedge clk);
        rst_n = 1'b1;

        send(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, NST);
        idle(6);

        send(2'b01, 64'd5, 64'd5, 1'b1, NST);
        send(2'b01, 64'd1, 64'h8000_0000_0000_0000, 1'b1, NST);
        send(2'b11, 64'hF0F0, 64'hFFFF, 1'b0, NST);
        send(2'b10, 64'hFF00_FF00_1234_5678, 64'h0F0F_F0F0_FFFF_0000, 1'b1, NST);
        send(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, NST);
        idle(6);

        for (int i = 0; i < 8; i++) send(2'b00, 64'(i), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, NST);
        idle(6);

        t0 = cyc;
        stall_lo = t0 + 5;
        stall_hi = t0 + 7;
        for (int i = 0; i < 8; i++) send(2'b00, 64'(i), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        idle(10);
        stall_lo = -1;
        stall_hi = -1;

        rnd_ordy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), 0);
        end
        rnd_ordy = 1'b0;
        idle(20);
        chk("drain_mid", sbq.size(), 0);

        stall_lo = cyc;
        stall_hi = cyc + 100000;
        send(2'b00, 64'd10, 64'd20, 1'b1, 0);
        send(2'b01, 64'd3, 64'd1, 1'b1, 0);
        send(2'b11, 64'hAAAA, 64'h5555, 1'b1, 0);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 10) begin
            idle(1);
            guard++;
        end
        chk("pre_reset_valid", out_valid, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        sbq.delete();
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_result", result, 0);
        chk("async_rst_overflow", overflow, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_cc_zf", cc_zf, 1);
        chk("async_rst_cc_sf", cc_sf, 0);
        chk("async_rst_cc_of", cc_of, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stall_lo = -1;
        stall_hi = -1;
        send(2'b00, 64'd3, 64'd4, 1'b1, NST);
        idle(8);
        chk("drain_end", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 16, bits of carry chain resolved per pipeline stage; WIDTH SHALL be a multiple of CHUNK; NSTAGE = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands/op presented.
REQ-006 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port op  input  2  00 ADD, 01 SUB, 10 AND, 11 XOR.
REQ-008 SHALL have port a  input  WIDTH  operand A (signed, two's complement).
REQ-009 SHALL have port b  input  WIDTH  operand B (signed, two's complement).
REQ-010 SHALL have port set_cc  input  1  this op updates condition codes.
REQ-011 SHALL have port out_valid  output  1  result presented.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  WIDTH  operation result.
REQ-014 SHALL have port overflow  output  1  signed overflow of the presented result.
REQ-015 SHALL have ports cc_zf, cc_sf, cc_of  output  1 each  condition-code register.

Function
REQ-016 ADD SHALL compute a+b mod 2^WIDTH; SUB SHALL compute b-a mod 2^WIDTH (b + ~a + 1); AND/XOR bitwise.
REQ-017 overflow SHALL be 1 for ADD when sign(a)==sign(b) and sign(result)!=sign(a); for SUB when sign(a)!=sign(b) and sign(result)!=sign(b); 0 for AND/XOR.
REQ-018 Carry SHALL ripple CHUNK bits per stage, registered carry between stages; no stage combines more than CHUNK bits of carry chain.
REQ-019 Latency SHALL be exactly NSTAGE cycles from input handshake (in_valid&&in_ready) to out_valid, absent stalls; throughput one op per cycle.
REQ-020 stall = out_valid && !out_ready; in_ready SHALL equal !stall; on stall every stage, including bubbles, SHALL hold.
REQ-021 result/overflow SHALL stay stable while out_valid && !out_ready.
REQ-022 Results SHALL emerge in acceptance order; no op lost or duplicated under any in_valid/out_ready pattern.
REQ-023 in_valid with in_ready=0 SHALL NOT be captured; source holds inputs.
REQ-024 NSTAGE==1 SHALL be legal: single registered stage, latency 1.

Reset
REQ-025 rst_n low SHALL immediately clear all stage valid bits, out_valid=0, result=0, overflow=0, cc_zf=1, cc_sf=0, cc_of=0, independent of clk.
REQ-026 Ops in flight at reset assertion SHALL be discarded; first accept after release SHALL be the first op delivered.
REQ-027 in_ready SHALL be 1 while rst_n is low and after release (pipeline empty).

Configuration
REQ-028 Macro ALU_PIPE_CC_EN defined: on output handshake of an op with set_cc=1, cc_zf<=(result==0), cc_sf<=result[WIDTH-1], cc_of<=overflow; otherwise CC holds.
REQ-029 ALU_PIPE_CC_EN undefined: cc_zf/cc_sf/cc_of SHALL be constant at reset values (1,0,0), set_cc ignored, no CC flops.

Verification
REQ-030 WIDTH=64,CHUNK=16: ADD a=0x7FFFFFFFFFFFFFFF b=1 -> after 4 cycles result=0x8000000000000000, overflow=1; with CC_EN and set_cc=1 -> cc_sf=1, cc_of=1, cc_zf=0.
REQ-031 SUB a=5 b=5 -> result=0, overflow=0, cc_zf=1; SUB a=1 b=0x8000000000000000 -> result=0x7FFFFFFFFFFFFFFF, overflow=1.
REQ-032 Back-to-back 8 ADDs (a=i, b=0xFFFFFFFFFFFFFFFF, i=0..7) with out_ready=1 -> 8 results a-1 on consecutive cycles starting cycle 4; carry across all chunks correct for i>=1.
REQ-033 Same stream with out_ready low cycles 5-7 -> in_ready=0 those cycles, result held, all 8 delivered in order, none duplicated.
REQ-034 XOR a=0xF0F0 b=0xFFFF with set_cc=0 -> result=0x0F0F, overflow=0, CC unchanged.
REQ-035 Assert rst_n low mid-stream (3 ops in flight) -> out_valid=0 same cycle, CC=(1,0,0); next op after release delivered first with latency 4.
